// File: rtl/mcpnr_switch_pkg.sv
// Shared constants and helpers for the MCPNR switch reader: default sizing,
// event field layout and a counter-width helper.
package mcpnr_switch_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_FIFO_DEPTH      = 4;

    // An event word is {level, mask}; the enum value is the slot index, mask in the low slot.
    typedef enum int {
        EVT_FIELD_MASK  = 0,
        EVT_FIELD_LEVEL = 1
    } evtField_e;

    localparam int EVT_FIELD_COUNT = 2;

    function automatic int clog2Min1(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/mcpnr_sync_fifo.sv
// Small synchronous FIFO with registered storage; the head reads zero while empty
// and a push while full is only taken when a pop frees a slot on the same edge.
module mcpnr_sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             doPush;
    logic             doPop;

    // The extra pointer bit separates full from empty when the index bits match.
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);
    assign data_o  = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_ONE;
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/mcpnr_switch_reader.sv
// Reader for an MCPNR_SWITCHES bank: synchronises and debounces each switch bit and
// queues every debounced change as a {level, mask} event on a valid/ready stream.
module mcpnr_switch_reader
    import mcpnr_switch_pkg::*;
#(
    parameter int NSWITCH         = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int FIFO_DEPTH      = DEFAULT_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NSWITCH-1:0] sw_i,
    output logic [NSWITCH-1:0] state_o,
    output logic               evt_valid_o,
    input  logic               evt_ready_i,
    output logic [NSWITCH-1:0] evt_level_o,
    output logic [NSWITCH-1:0] evt_mask_o,
    output logic               overflow_o,
    input  logic               overflow_clr_i
);

    localparam int              CNT_W     = clog2Min1(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int              EVT_W     = EVT_FIELD_COUNT * NSWITCH;
    localparam int              LEVEL_LSB = int'(EVT_FIELD_LEVEL) * NSWITCH;
    localparam int              MASK_LSB  = int'(EVT_FIELD_MASK) * NSWITCH;

    logic [NSWITCH-1:0] sync1_q;
    logic [NSWITCH-1:0] sync2_q;
    logic [NSWITCH-1:0] stable_q;
    logic [NSWITCH-1:0] stable_d;
    logic [NSWITCH-1:0] commitMask;
    logic [EVT_W-1:0]   evtData;
    logic [EVT_W-1:0]   headData;
    logic               pushReq;
    logic               popReq;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               pushDropped;
    logic               overflow_d;
    logic               overflow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
        end
    end

    // Each bit counts consecutive cycles its synchronised level disagrees with the stable level.
    for (genvar gi = 0; gi < NSWITCH; gi++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             differs;

        assign differs        = (sync2_q[gi] != stable_q[gi]);
        assign commitMask[gi] = differs && (cnt_q == CNT_LAST);

        always_comb begin
            cnt_d = cnt_q;
            if (!differs || commitMask[gi]) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign stable_d = stable_q ^ commitMask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_q <= '0;
        end else begin
            stable_q <= stable_d;
        end
    end

    always_comb begin
        evtData = '0;
        evtData[LEVEL_LSB +: NSWITCH] = stable_d;
        evtData[MASK_LSB  +: NSWITCH] = commitMask;
    end

    assign pushReq     = |commitMask;
    assign popReq      = !fifoEmpty && evt_ready_i;
    assign pushDropped = pushReq && fifoFull && !popReq;

    mcpnr_sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pushReq),
        .data_i  (evtData),
        .pop_i   (popReq),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .data_o  (headData)
    );

    // A drop on the same edge as a clear keeps the flag set so the loss is never hidden.
    always_comb begin
        overflow_d = overflow_q;
        if (pushDropped) begin
            overflow_d = 1'b1;
        end else if (overflow_clr_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign state_o     = stable_q;
    assign evt_valid_o = !fifoEmpty;
    assign evt_level_o = headData[LEVEL_LSB +: NSWITCH];
    assign evt_mask_o  = headData[MASK_LSB  +: NSWITCH];
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_mcpnr_switch_reader.sv
// Self-checking bench for mcpnr_switch_reader: directed scenarios plus random stimulus,
// all compared against an event-level reference model of the switch reader.
module tb_mcpnr_switch_reader;

    localparam int N     = 2;
    localparam int DC    = 4;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rstN;
    logic [N-1:0] sw;
    logic [N-1:0] stateO;
    logic         evtValid;
    logic         evtReady;
    logic [N-1:0] evtLevel;
    logic [N-1:0] evtMask;
    logic         overflowO;
    logic         overflowClr;

    int errors = 0;
    int checks = 0;

    // Reference model state: two-stage delay line, committed levels, run lengths, event queue.
    logic [N-1:0]   mS1;
    logic [N-1:0]   mS2;
    logic [N-1:0]   mStable;
    int             mRun [N];
    logic [2*N-1:0] mQ [$];
    logic           mOvf;

    mcpnr_switch_reader #(
        .NSWITCH         (N),
        .DEBOUNCE_CYCLES (DC),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rstN),
        .sw_i           (sw),
        .state_o        (stateO),
        .evt_valid_o    (evtValid),
        .evt_ready_i    (evtReady),
        .evt_level_o    (evtLevel),
        .evt_mask_o     (evtMask),
        .overflow_o     (overflowO),
        .overflow_clr_i (overflowClr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A bit commits once its delayed level has disagreed with the committed level for DC edges in a row.
    task automatic modelEdge();
        logic [N-1:0] commit;
        bit           dropped;
        commit  = '0;
        dropped = 0;
        if (!rstN) begin
            mS1 = '0;
            mS2 = '0;
            mStable = '0;
            for (int i = 0; i < N; i++) mRun[i] = 0;
            mQ.delete();
            mOvf = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (mS2[i] != mStable[i]) begin
                    mRun[i]++;
                    if (mRun[i] == DC) begin
                        commit[i] = 1'b1;
                        mRun[i] = 0;
                    end
                end else begin
                    mRun[i] = 0;
                end
            end
            if (mQ.size() > 0 && evtReady) void'(mQ.pop_front());
            if (commit != '0) begin
                if (mQ.size() < DEPTH) mQ.push_back({mStable ^ commit, commit});
                else dropped = 1;
            end
            mStable = mStable ^ commit;
            if (dropped) mOvf = 1'b1;
            else if (overflowClr) mOvf = 1'b0;
            mS2 = mS1;
            mS1 = sw;
        end
    endtask

    function automatic logic [3*N+1:0] modelOut();
        logic [2*N-1:0] head;
        head = (mQ.size() > 0) ? mQ[0] : '0;
        return {mStable, (mQ.size() > 0), head, mOvf};
    endfunction

    function automatic logic [3*N+1:0] dutOut();
        return {stateO, evtValid, evtLevel, evtMask, overflowO};
    endfunction

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] swVal, input logic readyVal, input logic clrVal);
        sw          = swVal;
        evtReady    = readyVal;
        overflowClr = clrVal;
    endtask

    // Drives a level, holds it for a number of edges, comparing with the model after each edge.
    task automatic holdAndCompare(input string name, input logic [N-1:0] swVal, input int cycles);
        sw = swVal;
        for (int k = 0; k < cycles; k++) begin
            tick();
            checks++;
            if (dutOut() !== modelOut()) begin
                errors++;
                $display("[TB] FAIL %s t=%0t got=%h exp=%h", name, $time, dutOut(), modelOut());
            end
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        applyStimulus('0, 1'b1, 1'b0);
        tick();
        tick();
        checks++;
        if (stateO !== '0 || evtValid !== 1'b0 || overflowO !== 1'b0 || evtLevel !== '0 || evtMask !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state got=%h exp=0", dutOut());
        end
        rstN = 1'b1;
        holdAndCompare("reset_idle", '0, 4);
    endtask

    task automatic test_glitch();
        holdAndCompare("glitch_pulse", 2'b01, 3);
        for (int k = 0; k < 10; k++) begin
            sw = 2'b00;
            tick();
            checks++;
            if (evtValid !== 1'b0 || stateO !== 2'b00 || dutOut() !== modelOut()) begin
                errors++;
                $display("[TB] FAIL glitch_reject got=%h exp=%h", dutOut(), modelOut());
            end
        end
    endtask

    task automatic test_single_event();
        evtReady = 1'b1;
        sw = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (evtValid !== (k == 6)) begin
                errors++;
                $display("[TB] FAIL single_latency edge=%0d got=%b exp=%b", k, evtValid, (k == 6));
            end
            if (k == 6) begin
                checks++;
                if (evtLevel !== 2'b01 || evtMask !== 2'b01 || stateO !== 2'b01) begin
                    errors++;
                    $display("[TB] FAIL single_event got lvl=%b msk=%b st=%b exp 01/01/01", evtLevel, evtMask, stateO);
                end
            end
        end
    endtask

    task automatic test_merge();
        int seen;
        holdAndCompare("merge_settle", 2'b00, 8);
        seen = 0;
        sw = 2'b11;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (evtValid) begin
                seen++;
                checks++;
                if (evtLevel !== 2'b11 || evtMask !== 2'b11) begin
                    errors++;
                    $display("[TB] FAIL merge_event got lvl=%b msk=%b exp 11/11", evtLevel, evtMask);
                end
            end
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("[TB] FAIL merge_count got=%0d exp=1", seen);
        end
    endtask

    task automatic test_overflow();
        logic [N-1:0]   base;
        logic [2*N-1:0] got [$];
        base = mStable;
        evtReady = 1'b0;
        for (int t = 0; t < 5; t++) holdAndCompare("ovf_fill", mStable ^ 2'b01, 8);
        checks++;
        if (overflowO !== 1'b1 || evtValid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_set got ovf=%b vld=%b exp 1/1", overflowO, evtValid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (evtLevel !== (base ^ 2'b01) || evtMask !== 2'b01) begin
                errors++;
                $display("[TB] FAIL ovf_head_stall got lvl=%b msk=%b exp %b/01", evtLevel, evtMask, base ^ 2'b01);
            end
        end
        evtReady = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (evtValid) got.push_back({evtLevel, evtMask});
            tick();
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("[TB] FAIL ovf_drain_count got=%0d exp=4", got.size());
        end
        for (int j = 0; j < got.size() && j < 4; j++) begin
            checks++;
            if (got[j] !== {((j % 2 == 0) ? (base ^ 2'b01) : base), 2'b01}) begin
                errors++;
                $display("[TB] FAIL ovf_drain_order idx=%0d got=%h exp=%h", j, got[j],
                         {((j % 2 == 0) ? (base ^ 2'b01) : base), 2'b01});
            end
        end
        overflowClr = 1'b1;
        tick();
        overflowClr = 1'b0;
        checks++;
        if (overflowO !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_clear got=%b exp=0", overflowO);
        end
    endtask

    task automatic test_full_pop_same_edge();
        logic [N-1:0] base;
        logic [N-1:0] lastLevel;
        int           popped;
        base = mStable;
        evtReady = 1'b0;
        for (int t = 0; t < 4; t++) holdAndCompare("fullpop_fill", mStable ^ 2'b01, 8);
        sw = mStable ^ 2'b01;
        for (int k = 1; k <= 8; k++) begin
            evtReady = (k == 6);
            tick();
        end
        evtReady = 1'b0;
        checks++;
        if (overflowO !== 1'b0 || dutOut() !== modelOut()) begin
            errors++;
            $display("[TB] FAIL fullpop_no_overflow got=%h exp=%h", dutOut(), modelOut());
        end
        popped = 0;
        lastLevel = '0;
        evtReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (evtValid) begin
                popped++;
                lastLevel = evtLevel;
            end
            tick();
        end
        checks++;
        if (popped != 4 || lastLevel !== (base ^ 2'b01)) begin
            errors++;
            $display("[TB] FAIL fullpop_count got=%0d/%b exp=4/%b", popped, lastLevel, base ^ 2'b01);
        end
    endtask

    task automatic test_reset_mid();
        evtReady = 1'b0;
        holdAndCompare("rstmid_evt", mStable ^ 2'b01, 8);
        holdAndCompare("rstmid_evt", mStable ^ 2'b01, 8);
        holdAndCompare("rstmid_count", mStable ^ 2'b10, 4);
        rstN = 1'b0;
        sw = 2'b01;
        tick();
        checks++;
        if (evtValid !== 1'b0 || stateO !== 2'b00 || overflowO !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_clear got vld=%b st=%b ovf=%b exp 0/00/0", evtValid, stateO, overflowO);
        end
        rstN = 1'b1;
        evtReady = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (evtValid !== (k == 6) || (k == 6 && (evtLevel !== 2'b01 || evtMask !== 2'b01))) begin
                errors++;
                $display("[TB] FAIL rstmid_fresh edge=%0d got vld=%b lvl=%b msk=%b", k, evtValid, evtLevel, evtMask);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) sw = N'($urandom);
            evtReady    = ($urandom_range(0, 2) == 0);
            overflowClr = ($urandom_range(0, 9) == 0);
            rstN        = ($urandom_range(0, 299) != 0);
            tick();
            checks++;
            if (dutOut() !== modelOut()) begin
                errors++;
                $display("[TB] FAIL random cyc=%0d got=%h exp=%h", k, dutOut(), modelOut());
            end
        end
        rstN = 1'b1;
        overflowClr = 1'b0;
    endtask

    initial begin
        mS1 = '0;
        mS2 = '0;
        mStable = '0;
        mOvf = 1'b0;
        for (int i = 0; i < N; i++) mRun[i] = 0;
        rstN = 1'b0;
        applyStimulus('0, 1'b1, 1'b0);
        test_reset();
        test_glitch();
        test_single_event();
        test_merge();
        test_overflow();
        test_full_pop_same_edge();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
